// File: rtl/title_pkg.sv
// rtl/title_pkg.sv - shared mode encodings, colour and glyph geometry for the title renderer
package title_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC       = 2'd0,
      MODE_CYCLE        = 2'd1,
      MODE_BLINK_CYC    = 2'd2,
      MODE_BLINK_STATIC = 2'd3
   } mode_e;

   localparam logic [2:0] COLOR_BLACK = 3'b000;
   localparam int         GLYPH_W     = 8;
   localparam int         GLYPH_H     = 16;

   // Walks the seven non-black colours; black is skipped on wrap.
   function automatic logic [2:0] next_color(input logic [2:0] c);
      return (c == 3'b111) ? 3'b001 : c + 3'b001;
   endfunction

endpackage

// File: rtl/title_text_engine_rom.sv
// rtl/title_text_engine_rom.sv - synchronous-read glyph row ROM, one cycle latency
module title_rom #(
   parameter int                  DEPTH = 2048,
   parameter int                  AW    = 11,
   parameter logic [DEPTH*8-1:0]  INIT  = '0
) (
   input  logic          clk,
   input  logic [AW-1:0] i_addr,
   output logic [7:0]    o_data
);

   logic [7:0] r_data;

   // Contents are a packed constant: byte n lives at bits [8n+7:8n].
   always_ff @(posedge clk) begin
      r_data <= INIT[{i_addr, 3'b000} +: 8];
   end

   assign o_data = r_data;

endmodule

// File: rtl/title_text_engine.sv
// rtl/title_text_engine.sv - scaled 8x16 title text renderer with static, cycling and blinking colour
module title_text_engine
   import title_pkg::*;
#(
   parameter int COLS         = 32,
   parameter int ROWS         = 4,
   parameter int SCALE_LOG2   = 2,
   parameter int X0           = 0,
   parameter int Y0           = 0,
   parameter int CYCLE_PERIOD = 100_000_000,
   parameter int BLINK_PERIOD = 50_000_000,
   parameter logic [COLS*ROWS*GLYPH_H*8-1:0] ROM_INIT = '0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       video_on,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [1:0] mode,
   input  logic [2:0] static_color,
   output logic [2:0] rgb_text,
   output logic       text_on
);

   localparam int CW    = $clog2(COLS);
   localparam int RW    = $clog2(ROWS);
   localparam int DEPTH = COLS * ROWS * GLYPH_H;
   localparam int AW    = RW + CW + 4;
   localparam int WIN_W = COLS * (GLYPH_W << SCALE_LOG2);
   localparam int WIN_H = ROWS * (GLYPH_H << SCALE_LOG2);

   logic [10:0]   w_dx;
   logic [10:0]   w_dy;
   logic          w_in_win;
   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;
   logic [3:0]    w_glyph_row;
   logic [2:0]    w_bit_sel;
   logic [AW-1:0] w_rom_addr;
   logic [7:0]    w_font_word;

   assign w_dx = {1'b0, pixel_x} - 11'(X0);
   assign w_dy = {1'b0, pixel_y} - 11'(Y0);

   // The raw-coordinate test rejects pixels left/above the window whose dx/dy wrapped.
   assign w_in_win = ({22'd0, pixel_x} >= 32'(X0)) && ({21'd0, w_dx} < 32'(WIN_W)) &&
                     ({22'd0, pixel_y} >= 32'(Y0)) && ({21'd0, w_dy} < 32'(WIN_H));

   assign w_col       = CW'(w_dx >> (3 + SCALE_LOG2));
   assign w_row       = RW'(w_dy >> (4 + SCALE_LOG2));
   assign w_glyph_row = w_dy[SCALE_LOG2+3 -: 4];
   assign w_bit_sel   = w_dx[SCALE_LOG2+2 -: 3];
   assign w_rom_addr  = {w_row, w_col, w_glyph_row};

   title_rom #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .INIT  (ROM_INIT)
   ) u_rom (
      .clk    (clk),
      .i_addr (w_rom_addr),
      .o_data (w_font_word)
   );

   logic [2:0] r_bit_sel;
   logic       r_in_win;
   logic       r_video_on;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bit_sel  <= '0;
         r_in_win   <= 1'b0;
         r_video_on <= 1'b0;
      end else begin
         r_bit_sel  <= w_bit_sel;
         r_in_win   <= w_in_win;
         r_video_on <= video_on;
      end
   end

   logic [31:0] r_ccnt;
   logic [2:0]  r_cyc_color;
   logic [31:0] r_bcnt;
   logic        r_vis;

   // Both timers run in every mode so the colour/blink phase survives mode switches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ccnt      <= '0;
         r_cyc_color <= 3'b001;
      end else if (r_ccnt == 32'(CYCLE_PERIOD - 1)) begin
         r_ccnt      <= '0;
         r_cyc_color <= next_color(r_cyc_color);
      end else begin
         r_ccnt      <= r_ccnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bcnt <= '0;
         r_vis  <= 1'b1;
      end else if (r_bcnt == 32'(BLINK_PERIOD - 1)) begin
         r_bcnt <= '0;
         r_vis  <= ~r_vis;
      end else begin
         r_bcnt <= r_bcnt + 32'd1;
      end
   end

   mode_e      w_mode;
   logic [2:0] w_color;
   logic       w_vis;
   logic       w_lit;

   assign w_mode = mode_e'(mode);

   always_comb begin
      w_color = static_color;
      w_vis   = 1'b1;
      case (w_mode)
         MODE_CYCLE: w_color = r_cyc_color;
         MODE_BLINK_CYC: begin
            w_color = r_cyc_color;
            w_vis   = r_vis;
         end
         MODE_BLINK_STATIC: w_vis = r_vis;
         default: ;
      endcase
      w_lit = r_video_on & r_in_win & w_font_word[3'd7 - r_bit_sel] & w_vis;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb_text <= COLOR_BLACK;
         text_on  <= 1'b0;
      end else begin
         rgb_text <= w_lit ? w_color : COLOR_BLACK;
         text_on  <= w_lit;
      end
   end

endmodule

// File: tb/tb_title_text_engine.sv
// tb/tb_title_text_engine.sv - self-checking bench for title_text_engine against a behavioural model
module tb_title_text_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       video_on = 1'b0;
   logic [9:0] pixel_x = '0;
   logic [9:0] pixel_y = '0;
   logic [1:0] mode = '0;
   logic [2:0] static_color = '0;
   logic [2:0] rgb0, rgb1, rgb2;
   logic       on0, on1, on2;

   localparam logic [2048*8-1:0] ROM0 = {{1023{16'h5AC3}}, 8'h1E, 8'h80};
   localparam logic [1024*8-1:0] ROM1 = {1024{8'hFF}};
   localparam logic [2048*8-1:0] ROM2 = {2048{8'hFF}};

   always #5 clk = ~clk;

   title_text_engine #(.COLS(32), .ROWS(4), .SCALE_LOG2(2), .X0(0), .Y0(0),
                       .CYCLE_PERIOD(4), .BLINK_PERIOD(10), .ROM_INIT(ROM0)) dut0 (
      .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .mode(mode), .static_color(static_color), .rgb_text(rgb0), .text_on(on0));

   title_text_engine #(.COLS(16), .ROWS(4), .SCALE_LOG2(2), .X0(16), .Y0(8),
                       .CYCLE_PERIOD(5), .BLINK_PERIOD(7), .ROM_INIT(ROM1)) dut1 (
      .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .mode(mode), .static_color(static_color), .rgb_text(rgb1), .text_on(on1));

   title_text_engine #(.COLS(32), .ROWS(4), .SCALE_LOG2(2), .X0(0), .Y0(0),
                       .CYCLE_PERIOD(3), .BLINK_PERIOD(6), .ROM_INIT(ROM2)) dut2 (
      .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .mode(mode), .static_color(static_color), .rgb_text(rgb2), .text_on(on2));

   int checks = 0;
   int errors = 0;

   // Model state: pixel seen at the previous edge, and clock edges since reset release.
   int         k = 0;
   bit         p_valid = 1'b0;
   int         p_px, p_py;
   bit         p_von;
   logic [3:0] exp_out [3];
   logic [3:0] act_out [3];

   function automatic logic [7:0] glyph(input int inst, input int a);
      if (inst != 0) return 8'hFF;
      if (a == 0) return 8'h80;
      if (a == 1) return 8'h1E;
      return (a % 2 == 1) ? 8'h5A : 8'hC3;
   endfunction

   // Returns {text_on, rgb_text} for one instance from plain window/cell arithmetic.
   function automatic logic [3:0] model_out(input int inst, input int px, input int py,
                                            input bit von, input int md, input int sc, input int kk);
      int x0, y0, cols, cp, bp, dx, dy, addr, bsel, color;
      bit vis;
      logic [7:0] g;
      x0   = (inst == 1) ? 16 : 0;
      y0   = (inst == 1) ? 8 : 0;
      cols = (inst == 1) ? 16 : 32;
      cp   = (inst == 0) ? 4 : (inst == 1) ? 5 : 3;
      bp   = (inst == 0) ? 10 : (inst == 1) ? 7 : 6;
      dx   = px - x0;
      dy   = py - y0;
      if (!von || dx < 0 || dy < 0 || dx >= cols * 32 || dy >= 4 * 64) return 4'b0000;
      addr  = ((dy / 64) * cols + dx / 32) * 16 + (dy / 4) % 16;
      bsel  = (dx / 4) % 8;
      g     = glyph(inst, addr);
      vis   = (md < 2) || ((kk / bp) % 2 == 0);
      color = (md == 0 || md == 3) ? sc : 1 + (kk / cp) % 7;
      if (!(g[7 - bsel] && vis)) return 4'b0000;
      return {1'b1, 3'(color)};
   endfunction

   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 3; i++)
         exp_out[i] = (reset && p_valid) ?
                      model_out(i, p_px, p_py, p_von, int'(mode), int'(static_color), k) : 4'b0000;
      if (!reset) begin
         p_valid = 1'b0;
         k       = 0;
      end else begin
         p_valid = 1'b1;
         p_px    = int'(pixel_x);
         p_py    = int'(pixel_y);
         p_von   = video_on;
         k       = k + 1;
      end
      @(negedge clk);
      act_out[0] = {on0, rgb0};
      act_out[1] = {on1, rgb1};
      act_out[2] = {on2, rgb2};
   endtask

   task automatic test_reset();
      reset = 1'b0; video_on = 1'b1; pixel_x = 10'd0; pixel_y = 10'd0;
      mode = 2'd1; static_color = 3'b000;
      repeat (3) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_out[i] !== 4'b0000) begin
               errors++;
               $display("FAIL reset_hold dut%0d: got %b expected 0000", i, act_out[i]);
            end
         end
      end
      reset = 1'b1;
      repeat (6) tick();
      checks++;
      if (act_out[0] !== 4'b1010) begin
         errors++;
         $display("FAIL pre_reset_lit dut0: got %b expected 1010", act_out[0]);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({on0, rgb0, on2, rgb2} !== 8'h00) begin
         errors++;
         $display("FAIL reset_async: got %b/%b expected 0000/0000", {on0, rgb0}, {on2, rgb2});
      end
      repeat (5) begin
         tick();
         checks++;
         if (act_out[0] !== 4'b0000 || act_out[2] !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_frame: got %b/%b expected 0000/0000", act_out[0], act_out[2]);
         end
      end
      reset = 1'b1;
      tick();
      checks++;
      if (act_out[0] !== 4'b0000) begin
         errors++;
         $display("FAIL release_plus1 dut0: got %b expected 0000", act_out[0]);
      end
      tick();
      checks++;
      if (act_out[0] !== 4'b1001 || act_out[2] !== 4'b1001) begin
         errors++;
         $display("FAIL release_plus2: got %b/%b expected 1001/1001", act_out[0], act_out[2]);
      end
   endtask

   task automatic test_sweep();
      logic [3:0] e;
      mode = 2'd0; static_color = 3'b100; pixel_y = 10'd0; video_on = 1'b1;
      for (int x = 0; x <= 8; x++) begin
         pixel_x = 10'(x);
         tick();
         if (x >= 1) begin
            e = (x - 1 < 4) ? 4'b1100 : 4'b0000;
            checks++;
            if (act_out[0] !== e) begin
               errors++;
               $display("FAIL sweep x=%0d: got %b expected %b", x - 1, act_out[0], e);
            end
         end
      end
   endtask

   task automatic test_window();
      int         wx [6] = '{15, 16, 16, 527, 528, 16};
      int         wy [6] = '{8, 7, 8, 263, 8, 264};
      logic [3:0] we [6] = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
      mode = 2'd0; static_color = 3'b111; video_on = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pixel_x = 10'(wx[i]);
         pixel_y = 10'(wy[i]);
         tick();
         tick();
         checks++;
         if (act_out[1] !== we[i]) begin
            errors++;
            $display("FAIL window (%0d,%0d): got %b expected %b", wx[i], wy[i], act_out[1], we[i]);
         end
      end
   endtask

   task automatic test_cycle();
      logic [2:0] hist [36];
      logic [2:0] prev;
      int run, changes;
      mode = 2'd1; pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 36; i++) begin
         tick();
         hist[i] = act_out[0][2:0];
         checks++;
         if (act_out[0] !== exp_out[0] || act_out[0][3] !== 1'b1 || act_out[0][2:0] === 3'b000) begin
            errors++;
            $display("FAIL cycle_colour: got %b expected %b", act_out[0], exp_out[0]);
         end
      end
      prev = hist[0]; run = 1; changes = 0;
      for (int i = 1; i < 36; i++) begin
         if (hist[i] === prev) run++;
         else begin
            checks++;
            if (hist[i] !== ((prev == 3'b111) ? 3'b001 : prev + 3'b001)) begin
               errors++;
               $display("FAIL cycle_step: got %b after %b", hist[i], prev);
            end
            if (changes > 0) begin
               checks++;
               if (run != 4) begin
                  errors++;
                  $display("FAIL cycle_run_length: got %0d expected 4", run);
               end
            end
            changes++;
            prev = hist[i];
            run  = 1;
         end
      end
      checks++;
      if (changes < 8) begin
         errors++;
         $display("FAIL cycle_changes: got %0d expected >=8", changes);
      end
   endtask

   task automatic test_blink();
      bit prev, cur;
      int run, changes;
      mode = 2'd2; pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b1;
      tick();
      tick();
      prev = act_out[2][3]; run = 1; changes = 0;
      for (int i = 0; i < 48; i++) begin
         tick();
         checks++;
         if (act_out[2] !== exp_out[2]) begin
            errors++;
            $display("FAIL blink_colour: got %b expected %b", act_out[2], exp_out[2]);
         end
         cur = act_out[2][3];
         if (cur == prev) run++;
         else begin
            if (changes > 0) begin
               checks++;
               if (run != 6) begin
                  errors++;
                  $display("FAIL blink_run_length: got %0d expected 6", run);
               end
            end
            changes++;
            prev = cur;
            run  = 1;
         end
      end
      checks++;
      if (changes < 6) begin
         errors++;
         $display("FAIL blink_changes: got %0d expected >=6", changes);
      end
   endtask

   task automatic test_video_off();
      pixel_x = 10'd20; pixel_y = 10'd10; static_color = 3'b101;
      for (int md = 0; md < 4; md++) begin
         mode = 2'(md); video_on = 1'b0;
         tick();
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_out[i] !== 4'b0000) begin
               errors++;
               $display("FAIL video_off mode%0d dut%0d: got %b expected 0000", md, i, act_out[i]);
            end
         end
      end
      video_on = 1'b1; mode = 2'd1; pixel_x = 10'd0; pixel_y = 10'd0;
      tick();
      tick();
      checks++;
      if (act_out[0] !== exp_out[0] || act_out[2] !== exp_out[2]) begin
         errors++;
         $display("FAIL counters_run: got %b/%b expected %b/%b",
                  act_out[0], act_out[2], exp_out[0], exp_out[2]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         reset        = ($urandom_range(0, 63) != 0);
         video_on     = ($urandom_range(0, 7) != 0);
         pixel_x      = 10'($urandom_range(0, 640));
         pixel_y      = 10'($urandom_range(0, 300));
         mode         = 2'($urandom_range(0, 3));
         static_color = 3'($urandom_range(0, 7));
         tick();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_out[i] !== exp_out[i]) begin
               errors++;
               $display("FAIL random n=%0d dut%0d: got %b expected %b", n, i, act_out[i], exp_out[i]);
            end
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_window();
      test_cycle();
      test_blink();
      test_video_off();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
